// File: rtl/edge_detector_if.sv
// Purpose : bundles the sample stream and the edge/line reports of edge_detector.
// Ports   : master drives enb/lineReset/addrIn/pixelIn/threshold; slave drives
//           edgeValid/edgeAddr/edgeStrength/lineDone/lineEdges/lineIndex.
interface edge_detector_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 15
);
  // sample stream
  logic              enb;
  logic              lineReset;
  logic [ADDR_W-1:0] addrIn;
  logic [PIX_W-1:0]  pixelIn;
  logic [PIX_W-1:0]  threshold;

  // reports
  logic              edgeValid;
  logic [ADDR_W-1:0] edgeAddr;
  logic [PIX_W-1:0]  edgeStrength;
  logic              lineDone;
  logic [7:0]        lineEdges;
  logic [8:0]        lineIndex;

  // scan source / consumer side
  modport master (
    output enb, lineReset, addrIn, pixelIn, threshold,
    input  edgeValid, edgeAddr, edgeStrength, lineDone, lineEdges, lineIndex
  );

  // detector side
  modport slave (
    input  enb, lineReset, addrIn, pixelIn, threshold,
    output edgeValid, edgeAddr, edgeStrength, lineDone, lineEdges, lineIndex
  );
endinterface

// File: rtl/edge_detector.sv
// Purpose : horizontal edge detector; finds above-threshold gradient runs along a
//           scan line and reports each run's peak, plus per-line edge counts.
// Latency : edge and line reports appear 1 cycle after the closing sample.
// Flow    : no backpressure; a sample is consumed on every cycle with enb=1,
//           enb=0 freezes all state.
// Ports   : clk, resetIn (sync, active-high), bus (edge_detector_if.slave).
module edge_detector #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 15
) (
  input  logic            clk,
  input  logic            resetIn,
  edge_detector_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no previous pixel yet
    PRIME = 2'd1,  // previous pixel held, no open run
    RUN   = 2'd2   // above-threshold run open
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [PIX_W-1:0]  prev_pix;
  logic [PIX_W-1:0]  peak;
  logic [ADDR_W-1:0] peak_addr;
  logic [7:0]        edge_cnt;
  logic [7:0]        edge_cnt_nxt;
  logic              line_open;   // a sample was accepted since the last close/reset

  logic [PIX_W-1:0]  grad;
  logic              above;

  // control decoded from the FSM
  logic              open_run;
  logic              bump_peak;
  logic              report;
  logic              close_line;

  // |pixelIn - prevPix|: the magnitude of the difference of two PIX_W values
  // always fits in PIX_W bits, so ordering the subtraction avoids the sign bit.
  always_comb begin
    grad = '0;
    if (bus.pixelIn >= prev_pix) begin
      grad = bus.pixelIn - prev_pix;
    end else begin
      grad = prev_pix - bus.pixelIn;
    end
  end

  assign above = (grad > bus.threshold);

  // state register
  always_ff @(posedge clk) begin
    if (resetIn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and datapath controls
  always_comb begin
    state_nxt  = state;
    open_run   = 1'b0;
    bump_peak  = 1'b0;
    report     = 1'b0;
    close_line = 1'b0;

    if (bus.enb) begin
      case (state)
        IDLE: begin
          // first pixel only primes the difference
          state_nxt = PRIME;
        end
        PRIME: begin
          if (!bus.lineReset && above) begin
            open_run  = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (bus.lineReset || !above) begin
            // run ends either by falling below threshold or by the line ending
            report    = 1'b1;
            state_nxt = PRIME;
          end else if (grad > peak) begin
            // strict compare: on a tie the earlier address stays the peak
            bump_peak = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase

      // a new line never differences against the previous line's last pixel
      if (bus.lineReset) begin
        state_nxt  = PRIME;
        close_line = line_open;
      end
    end
  end

  // per-line edge count including this cycle's report, sticking at 255
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    if (report && (edge_cnt != 8'hFF)) begin
      edge_cnt_nxt = edge_cnt + 8'd1;
    end
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (resetIn) begin
      prev_pix         <= '0;
      peak             <= '0;
      peak_addr        <= '0;
      edge_cnt         <= '0;
      line_open        <= 1'b0;
      bus.edgeValid    <= 1'b0;
      bus.edgeAddr     <= '0;
      bus.edgeStrength <= '0;
      bus.lineDone     <= 1'b0;
      bus.lineEdges    <= '0;
      bus.lineIndex    <= '0;
    end else begin
      bus.edgeValid <= 1'b0;
      bus.lineDone  <= 1'b0;

      if (bus.enb) begin
        prev_pix  <= bus.pixelIn;
        line_open <= 1'b1;

        if (open_run || bump_peak) begin
          peak      <= grad;
          peak_addr <= bus.addrIn;
        end

        if (report) begin
          bus.edgeValid    <= 1'b1;
          bus.edgeAddr     <= peak_addr;
          bus.edgeStrength <= peak;
        end

        if (close_line) begin
          bus.lineDone  <= 1'b1;
          bus.lineEdges <= edge_cnt_nxt;
          bus.lineIndex <= bus.lineIndex + 9'd1;
          edge_cnt      <= '0;
        end else if (bus.lineReset) begin
          // first line after reset: nothing to close, start counting fresh
          edge_cnt      <= '0;
        end else begin
          edge_cnt      <= edge_cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: inputs driven at the falling edge,
// registered outputs checked at the next falling edge.
module tb_edge_detector;

  logic clk;
  logic resetIn;
  int   total;
  int   bad;
  int   ev_cnt;
  int   ld_cnt;

  edge_detector_if #(.PIX_W(8), .ADDR_W(15)) bus ();

  edge_detector #(.PIX_W(8), .ADDR_W(15)) dut (
    .clk     (clk),
    .resetIn (resetIn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [14:0] a, input logic [7:0] p, input logic lr);
    bus.enb       = 1'b1;
    bus.addrIn    = a;
    bus.pixelIn   = p;
    bus.lineReset = lr;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.enb       = 1'b0;
    bus.addrIn    = 15'($urandom);
    bus.pixelIn   = 8'($urandom);
    bus.lineReset = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetIn = 1'b1;
    bus.enb = 1'b0;
    @(negedge clk);
    resetIn = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetIn       = 1'b1;
    bus.enb       = 1'b0;
    bus.lineReset = 1'b0;
    bus.addrIn    = '0;
    bus.pixelIn   = '0;
    bus.threshold = 8'd20;
    @(negedge clk);
    @(negedge clk);
    resetIn = 1'b0;

    // reset state
    chk("rst_edgeValid", 32'(bus.edgeValid), 0);
    chk("rst_lineDone",  32'(bus.lineDone),  0);
    chk("rst_lineIndex", 32'(bus.lineIndex), 0);
    chk("rst_lineEdges", 32'(bus.lineEdges), 0);

    // line 10,10,50,90,92,92: peak 40 at addr 2, tie at addr 3 ignored
    smp(0, 10, 1'b0);  chk("a0_ev", 32'(bus.edgeValid), 0);
    smp(1, 10, 1'b0);  chk("a1_ev", 32'(bus.edgeValid), 0);
    smp(2, 50, 1'b0);  chk("a2_ev", 32'(bus.edgeValid), 0);
    smp(3, 90, 1'b0);  chk("a3_ev", 32'(bus.edgeValid), 0);
    smp(4, 92, 1'b0);
    chk("a4_ev",   32'(bus.edgeValid),    1);
    chk("a4_addr", 32'(bus.edgeAddr),     2);
    chk("a4_str",  32'(bus.edgeStrength), 40);
    smp(5, 92, 1'b0);
    chk("a5_ev",   32'(bus.edgeValid), 0);
    chk("a5_hold", 32'(bus.edgeAddr),  2);
    chk("a5_ld",   32'(bus.lineDone),  0);

    // end-of-line flush together with line close
    do_reset();
    smp(147, 0,   1'b0);
    smp(148, 0,   1'b0);
    smp(149, 100, 1'b0);
    chk("b149_ev", 32'(bus.edgeValid), 0);
    smp(150, 0,   1'b1);
    chk("b_ev",    32'(bus.edgeValid),    1);
    chk("b_addr",  32'(bus.edgeAddr),     149);
    chk("b_str",   32'(bus.edgeStrength), 100);
    chk("b_ld",    32'(bus.lineDone),     1);
    chk("b_edges", 32'(bus.lineEdges),    1);
    chk("b_index", 32'(bus.lineIndex),    1);

    // enb low in the middle of an open run
    smp(151, 60, 1'b0);
    chk("c_open_ld", 32'(bus.lineDone),  0);
    chk("c_hold_ed", 32'(bus.lineEdges), 1);
    for (int k = 0; k < 5; k++) begin
      idle();
      chk("c_idle_ev", 32'(bus.edgeValid), 0);
      chk("c_idle_ld", 32'(bus.lineDone),  0);
    end
    smp(152, 65, 1'b0);
    chk("c_ev",   32'(bus.edgeValid),    1);
    chk("c_addr", 32'(bus.edgeAddr),     151);
    chk("c_str",  32'(bus.edgeStrength), 60);

    // reset with a run open (peak 60), enb high during reset
    smp(153, 125, 1'b0);
    resetIn       = 1'b1;
    bus.enb       = 1'b1;
    bus.lineReset = 1'b1;
    bus.pixelIn   = 8'd0;
    @(negedge clk);
    resetIn = 1'b0;
    chk("d_ev",    32'(bus.edgeValid),    0);
    chk("d_ld",    32'(bus.lineDone),     0);
    chk("d_addr",  32'(bus.edgeAddr),     0);
    chk("d_str",   32'(bus.edgeStrength), 0);
    chk("d_edges", 32'(bus.lineEdges),    0);
    chk("d_index", 32'(bus.lineIndex),    0);
    smp(10, 200, 1'b1);
    chk("d_first_ld", 32'(bus.lineDone),  0);
    chk("d_first_ev", 32'(bus.edgeValid), 0);
    smp(11, 0, 1'b0);
    smp(12, 0, 1'b0);
    chk("d_ev2",   32'(bus.edgeValid),    1);
    chk("d_addr2", 32'(bus.edgeAddr),     11);
    chk("d_str2",  32'(bus.edgeStrength), 200);

    // saturation: 0,255,255,0,0,... gives a single-sample run per pair
    do_reset();
    bus.threshold = 8'd0;
    ev_cnt = 0;
    ld_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      smp(15'(i), (((i + 1) >> 1) & 1) != 0 ? 8'd255 : 8'd0, i == 0);
      if (bus.edgeValid) ev_cnt++;
      if (bus.lineDone)  ld_cnt++;
      if (i == 2) begin
        chk("e_first_addr", 32'(bus.edgeAddr),     1);
        chk("e_first_str",  32'(bus.edgeStrength), 255);
      end
    end
    chk("e_ev_count", 32'(ev_cnt), 299);
    chk("e_ld_count", 32'(ld_cnt), 0);
    smp(600, 0, 1'b1);
    chk("e_flush_ev", 32'(bus.edgeValid), 1);
    chk("e_flush_ad", 32'(bus.edgeAddr),  599);
    chk("e_ld",       32'(bus.lineDone),  1);
    chk("e_edges",    32'(bus.lineEdges), 255);
    chk("e_index",    32'(bus.lineIndex), 1);

    // lineReset on every sample: index wraps after 512 closes
    do_reset();
    ev_cnt = 0;
    ld_cnt = 0;
    for (int k = 1; k <= 513; k++) begin
      smp(15'(k), 8'($urandom), 1'b1);
      if (bus.edgeValid) ev_cnt++;
      if (bus.lineDone) begin
        ld_cnt++;
        if (bus.lineEdges != 8'd0) ev_cnt += 1000;
      end
      if (k == 512) chk("f_index_511", 32'(bus.lineIndex), 511);
    end
    chk("f_index_wrap", 32'(bus.lineIndex), 0);
    chk("f_ld_count",   32'(ld_cnt), 512);
    chk("f_no_edges",   32'(ev_cnt), 0);
    chk("f_ld_last",    32'(bus.lineDone), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
